// File: rtl/a2d_seq.sv
// a2d_seq: A2D conversion sequencer. Each round walks the enabled slots in
// ascending order. For every slot it issues two SPI transactions. The first
// selects the channel. The second reads back the conversion result.
//
// Ports:
//   clk, rst       clock; synchronous active-high reset
//   nxt, cont      start one round / run rounds back to back
//   ch_en          slot enable mask, latched at round start
//   wrt, cmd       one-cycle SPI start strobe and 16-bit command word
//   done, rd_data  SPI completion pulse and read data
//   result, vld    per-slot results and valid flags
//   rnd_done       one-cycle pulse in the final cycle of a round
//   busy           high whenever the sequencer is not idle
//   batt_low       registered low-battery flag for slot BATT_SLOT
module a2d_seq #(
  parameter int unsigned           NUM_CH      = 3,
  parameter int unsigned           DATA_W      = 12,
  parameter logic [NUM_CH*3-1:0]   CH_MAP      = {3'd5, 3'd4, 3'd0},
  parameter int unsigned           BATT_SLOT   = 2,
  parameter logic [DATA_W-1:0]     BATT_THRESH = 12'h800
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     nxt,
  input  logic                     cont,
  input  logic [NUM_CH-1:0]        ch_en,
  output logic                     wrt,
  output logic [15:0]              cmd,
  input  logic                     done,
  input  logic [15:0]              rd_data,
  output logic [NUM_CH*DATA_W-1:0] result,
  output logic [NUM_CH-1:0]        vld,
  output logic                     rnd_done,
  output logic                     busy,
  output logic                     batt_low
);

  localparam int unsigned SLOT_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [2:0] {StIdle, StCmd, StWaitCmd, StGap, StRd, StWaitRd, StAdv} state_e;

  state_e              state_q;
  logic [NUM_CH-1:0]   en_q;
  logic [SLOT_W-1:0]   slot_q;
  logic [SLOT_W-1:0]   first_slot;
  logic [SLOT_W-1:0]   next_slot;
  logic                has_next;

  // Only the low DATA_W bits of rd_data are stored.
  logic unused_rd;
  assign unused_rd = ^rd_data;

  // Lowest set bit of ch_en (round start) and next set bit of en_q above the
  // current slot (advance). Descending scans leave the lowest match behind.
  always_comb begin
    first_slot = '0;
    next_slot  = '0;
    has_next   = 1'b0;
    for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
      if (ch_en[i]) first_slot = SLOT_W'(i);
      if (en_q[i] && (i > int'(slot_q))) begin
        next_slot = SLOT_W'(i);
        has_next  = 1'b1;
      end
    end
  end

  function automatic logic [15:0] cmd_for(logic [SLOT_W-1:0] s);
    logic [2:0] code;
    code = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (SLOT_W'(i) == s) code = CH_MAP[3*i +: 3];
    end
    return {2'b00, code, 11'h000};
  endfunction

  assign busy = (state_q != StIdle);

  // wrt is raised on entry to CMD/RD so it is high for exactly that state.
  // rnd_done is raised on entry to the last ADV, which makes a continuous
  // restart land in CMD two cycles later.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      en_q     <= '0;
      slot_q   <= '0;
      wrt      <= 1'b0;
      cmd      <= '0;
      result   <= '0;
      vld      <= '0;
      rnd_done <= 1'b0;
    end else begin
      wrt      <= 1'b0;
      rnd_done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if ((nxt || cont) && (ch_en != '0)) begin
            en_q    <= ch_en;
            slot_q  <= first_slot;
            cmd     <= cmd_for(first_slot);
            wrt     <= 1'b1;
            state_q <= StCmd;
          end
        end
        StCmd:     state_q <= StWaitCmd;
        StWaitCmd: if (done) state_q <= StGap;
        StGap: begin
          wrt     <= 1'b1;
          state_q <= StRd;
        end
        StRd:      state_q <= StWaitRd;
        StWaitRd: begin
          if (done) begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
              if (SLOT_W'(i) == slot_q) begin
                result[i*DATA_W +: DATA_W] <= rd_data[DATA_W-1:0];
                vld[i]                     <= 1'b1;
              end
            end
            rnd_done <= !has_next;
            state_q  <= StAdv;
          end
        end
        StAdv: begin
          if (has_next) begin
            slot_q  <= next_slot;
            cmd     <= cmd_for(next_slot);
            wrt     <= 1'b1;
            state_q <= StCmd;
          end else begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  if (BATT_SLOT < NUM_CH) begin : g_batt
    always_ff @(posedge clk) begin
      if (rst) begin
        batt_low <= 1'b0;
      end else begin
        batt_low <= vld[BATT_SLOT] &&
                    (result[BATT_SLOT*DATA_W +: DATA_W] < BATT_THRESH);
      end
    end
  end else begin : g_no_batt
    assign batt_low = 1'b0;
  end

endmodule

// File: tb/tb_a2d_seq.sv
module tb_a2d_seq;

  logic        clk = 1'b0;
  logic        rst, nxt, cont, done;
  logic [2:0]  ch_en;
  logic        wrt;
  logic [15:0] cmd;
  logic [15:0] rd_data;
  logic [35:0] result;
  logic [2:0]  vld;
  logic        rnd_done, busy, batt_low;

  a2d_seq dut (
    .clk(clk), .rst(rst), .nxt(nxt), .cont(cont), .ch_en(ch_en),
    .wrt(wrt), .cmd(cmd), .done(done), .rd_data(rd_data),
    .result(result), .vld(vld), .rnd_done(rnd_done), .busy(busy),
    .batt_low(batt_low)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: channel codes per slot, last known results, battery flag.
  logic [2:0]  code_of [3] = '{3'd0, 3'd4, 3'd5};
  logic [11:0] res_m [3];
  logic [2:0]  vld_m;
  logic        batt_m;
  logic [11:0] spi_data [3];

  typedef struct {
    logic [35:0] res;
    logic [2:0]  vld;
    logic        bb;
    logic        ba;
  } rnd_exp_t;

  logic [15:0] exp_cmd [$];
  rnd_exp_t    exp_rnd [$];

  function automatic int slot_of_code(input logic [2:0] c);
    for (int s = 0; s < 3; s++) if (code_of[s] == c) return s;
    return 0;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 3; s++) res_m[s] = '0;
    vld_m  = '0;
    batt_m = 1'b0;
  endtask

  task automatic expect_round(input logic [2:0] mask);
    rnd_exp_t e;
    for (int s = 0; s < 3; s++) begin
      if (mask[s]) begin
        exp_cmd.push_back(16'(code_of[s]) << 11);
        exp_cmd.push_back(16'(code_of[s]) << 11);
        res_m[s] = spi_data[s];
        vld_m[s] = 1'b1;
      end
    end
    e.bb   = batt_m;
    batt_m = vld_m[2] && (res_m[2] < 12'h800);
    e.ba   = batt_m;
    e.res  = {res_m[2], res_m[1], res_m[0]};
    e.vld  = vld_m;
    exp_rnd.push_back(e);
  endtask

  // Monitor / scoreboard.
  int   wrt_cnt = 0;
  int   rnd_cnt = 0;
  logic prev_wrt = 1'b0;
  logic chk_batt = 1'b0;
  logic batt_next;

  initial begin : monitor
    logic [15:0] ec;
    rnd_exp_t    er;
    forever begin
      @(negedge clk);
      if (chk_batt) begin
        check("batt_low_after_round", batt_low, batt_next);
        chk_batt = 1'b0;
      end
      if (wrt) begin
        wrt_cnt++;
        check("wrt_one_cycle", prev_wrt, 1'b0);
        if (exp_cmd.size() == 0) begin
          total++;
          $display("FAIL unexpected_wrt: cmd %0h with no transaction expected", cmd);
        end else begin
          ec = exp_cmd.pop_front();
          check("cmd", cmd, ec);
        end
      end
      prev_wrt = wrt;
      if (rnd_done) begin
        rnd_cnt++;
        if (exp_rnd.size() == 0) begin
          total++;
          $display("FAIL unexpected_rnd_done: result %0h with no round expected", result);
        end else begin
          er = exp_rnd.pop_front();
          check("round_result", result, er.res);
          check("round_vld", vld, er.vld);
          check("batt_low_at_rnd_done", batt_low, er.bb);
          chk_batt  = 1'b1;
          batt_next = er.ba;
        end
      end
    end
  end

  // SPI slave model: done after a latency, optional spurious done in GAP.
  int   fix_lat  = 0;
  logic idle_req = 1'b0;

  initial begin : spi_model
    int          cnt;
    logic        phase, spur;
    logic [15:0] pend;
    cnt = 0; phase = 1'b0; spur = 1'b0; pend = '0;
    done = 1'b0; rd_data = '0;
    forever begin
      @(negedge clk);
      done    = 1'b0;
      rd_data = 16'($urandom);
      if (spur) begin
        done = 1'b1;
        spur = 1'b0;
      end
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          done    = 1'b1;
          rd_data = pend;
          if (!phase && ($urandom_range(0, 2) == 0)) spur = 1'b1;
          phase = !phase;
        end
      end
      if (wrt && !rst) begin
        cnt  = (fix_lat != 0) ? fix_lat : int'($urandom_range(1, 20));
        pend = {4'h0, spi_data[slot_of_code(cmd[13:11])]};
      end
      if (rst) phase = 1'b0;
      if (idle_req && cnt == 0) begin
        done     = 1'b1;
        idle_req = 1'b0;
      end
    end
  end

  task automatic wait_rnd(input string name);
    logic seen = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (rnd_done) begin
        seen = 1'b1;
        break;
      end
    end
    check(name, seen, 1'b1);
  endtask

  task automatic run_round(input logic [2:0] mask, input logic noise);
    int w0;
    w0 = wrt_cnt;
    expect_round(mask);
    ch_en = mask;
    @(negedge clk); nxt = 1'b1;
    @(negedge clk); nxt = 1'b0;
    if (noise) begin
      ch_en = 3'($urandom);
      @(negedge clk);
      @(negedge clk);
      if (busy) nxt = 1'b1;
      @(negedge clk); nxt = 1'b0;
    end
    wait_rnd("round_completes");
    @(negedge clk);
    check("wrt_count", wrt_cnt - w0, 2 * $countones(mask));
  endtask

  task automatic rand_data();
    for (int s = 0; s < 3; s++) spi_data[s] = 12'($urandom);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin : main
    int r0, w0, k;
    logic busy_seen;
    rst = 1'b1; nxt = 1'b0; cont = 1'b0; ch_en = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_wrt", wrt, 1'b0);
    check("rst_cmd", cmd, 16'h0);
    check("rst_result", result, 36'h0);
    check("rst_vld", vld, 3'b000);
    check("rst_busy", busy, 1'b0);
    check("rst_batt", batt_low, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // Basic round with known data.
    spi_data[0] = 12'h000; spi_data[1] = 12'h111; spi_data[2] = 12'h222;
    r0 = rnd_cnt;
    run_round(3'b111, 1'b0);
    repeat (10) @(negedge clk);
    check("basic_result", result, 36'h222111000);
    check("basic_vld", vld, 3'b111);
    check("basic_rnd_done_count", rnd_cnt - r0, 1);

    // Slot 1 disabled keeps its old value.
    rand_data();
    run_round(3'b101, 1'b0);
    check("slot1_kept", result[23:12], 12'h111);

    // Empty mask: nxt ignored.
    w0 = wrt_cnt;
    busy_seen = 1'b0;
    ch_en = 3'b000;
    @(negedge clk); nxt = 1'b1;
    @(negedge clk); nxt = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      busy_seen |= busy;
    end
    check("empty_mask_busy", busy_seen, 1'b0);
    check("empty_mask_wrt", wrt_cnt - w0, 0);

    // Low-battery threshold edges.
    rand_data(); spi_data[2] = 12'h7FF;
    run_round(3'b111, 1'b0);
    @(negedge clk);
    check("batt_low_7ff", batt_low, 1'b1);
    rand_data(); spi_data[2] = 12'h800;
    run_round(3'b111, 1'b0);
    @(negedge clk);
    check("batt_low_800", batt_low, 1'b0);

    // Random rounds with mid-round nxt, ch_en changes and idle done noise.
    for (int n = 0; n < 10; n++) begin
      rand_data();
      run_round(3'($urandom_range(1, 7)), 1'b1);
      idle_req = 1'b1;
      repeat ($urandom_range(2, 6)) @(negedge clk);
    end

    // Continuous mode: three rounds, cont dropped during the third.
    r0 = rnd_cnt;
    rand_data();
    expect_round(3'b111);
    ch_en = 3'b111;
    @(negedge clk); cont = 1'b1;
    wait_rnd("cont_round1");
    for (int r = 1; r < 3; r++) begin
      rand_data();
      expect_round(3'b111);
      k = 0;
      for (int i = 1; i <= 6; i++) begin
        @(negedge clk);
        if (wrt) begin
          k = i;
          break;
        end
      end
      check("cont_restart_gap", k, 2);
      if (r == 2) cont = 1'b0;
      wait_rnd("cont_round_next");
    end
    repeat (10) @(negedge clk);
    check("cont_rnd_done_count", rnd_cnt - r0, 3);
    check("cont_busy_after", busy, 1'b0);

    // Reset while waiting for read data.
    fix_lat = 20;
    rand_data();
    expect_round(3'b111);
    ch_en = 3'b111;
    w0 = wrt_cnt;
    @(negedge clk); nxt = 1'b1;
    @(negedge clk); nxt = 1'b0;
    for (int i = 0; i < 200 && wrt_cnt < w0 + 2; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    exp_cmd.delete();
    exp_rnd.delete();
    model_reset();
    @(negedge clk);
    check("midrst_wrt", wrt, 1'b0);
    check("midrst_cmd", cmd, 16'h0);
    check("midrst_result", result, 36'h0);
    check("midrst_vld", vld, 3'b000);
    check("midrst_rnd_done", rnd_done, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_batt", batt_low, 1'b0);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check("late_done_vld", vld, 3'b000);
    check("late_done_busy", busy, 1'b0);
    fix_lat = 0;
    rand_data();
    run_round(3'b111, 1'b0);

    repeat (5) @(negedge clk);
    check("cmd_queue_empty", exp_cmd.size(), 0);
    check("rnd_queue_empty", exp_rnd.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/a2d_seq.md
A2D_SEQ -- requirements
Module: a2d_seq

Interface
REQ-001 SHALL have parameter NUM_CH, default 3: number of sequenced conversion slots, legal range 1-8.
REQ-002 SHALL have parameter DATA_W, default 12: conversion result width, legal range 1-16.
REQ-003 SHALL have parameter CH_MAP, default {3'd5,3'd4,3'd0}, width NUM_CH*3: A2D channel code of slot i, taken from CH_MAP[3i+2:3i].
REQ-004 SHALL have parameter BATT_SLOT, default 2: slot compared for the low-battery flag.
REQ-005 SHALL have parameter BATT_THRESH, default 12'h800: low-battery threshold, DATA_W bits wide.
REQ-006 SHALL have port clk, input, 1 bit: the only clock; all state changes on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port nxt, input, 1 bit: start one round.
REQ-009 SHALL have port cont, input, 1 bit: continuous mode.
REQ-010 SHALL have port ch_en, input, NUM_CH bits: slot enable mask.
REQ-011 SHALL have port wrt, output, 1 bit: one-cycle start strobe to the SPI master.
REQ-012 SHALL have port cmd, output, 16 bits: SPI command word.
REQ-013 SHALL have port done, input, 1 bit: SPI transaction complete, one-cycle pulse.
REQ-014 SHALL have port rd_data, input, 16 bits: SPI read data, valid in the cycle done is high.
REQ-015 SHALL have port result, output, NUM_CH*DATA_W bits: slot i result at [DATA_W*i +: DATA_W].
REQ-016 SHALL have port vld, output, NUM_CH bits: vld[i] high once slot i holds a result.
REQ-017 SHALL have port rnd_done, output, 1 bit: one-cycle pulse at round end.
REQ-018 SHALL have port busy, output, 1 bit: high in every state other than IDLE.
REQ-019 SHALL have port batt_low, output, 1 bit: high when result[BATT_SLOT] < BATT_THRESH and vld[BATT_SLOT] is high.

Function
REQ-020 SHALL implement the states IDLE, CMD, WAIT_CMD, GAP, RD, WAIT_RD and ADV.
REQ-021 SHALL leave IDLE for CMD when nxt=1 or cont=1, provided ch_en != 0; SHALL latch ch_en into en_q on that transition, and SHALL set the slot pointer to the lowest set bit.
REQ-022 SHALL ignore nxt or cont while ch_en is 0, with no wrt pulse and busy held low.
REQ-023 In CMD, SHALL assert wrt for exactly one cycle with cmd = {2'b00, CH_MAP[slot], 11'h000}, then move to WAIT_CMD.
REQ-024 In WAIT_CMD, SHALL hold cmd steady and move to GAP on done.
REQ-025 SHALL spend exactly one cycle in GAP, then move to RD.
REQ-026 In RD, SHALL pulse wrt once, with cmd unchanged, then move to WAIT_RD.
REQ-027 On done in WAIT_RD, SHALL write rd_data[DATA_W-1:0] into result slot, set vld[slot], and move to ADV.
REQ-028 In ADV, SHALL advance the pointer to the next higher set bit of en_q; if none remains, SHALL pulse rnd_done and return to IDLE; otherwise SHALL go to CMD.
REQ-029 A round with k enabled slots SHALL produce exactly 2k wrt pulses.
REQ-030 Disabled slots SHALL keep their previous result and vld value.
REQ-031 nxt pulses while busy is high SHALL be dropped and not queued.
REQ-032 Changes to ch_en mid-round SHALL take effect only at the next round start.
REQ-033 With cont high at rnd_done, SHALL re-enter CMD two cycles later (IDLE for one cycle); cont deasserting mid-round SHALL let the current round finish.
REQ-034 done outside WAIT_CMD and WAIT_RD SHALL be ignored.
REQ-035 Simultaneous done and rnd_done SHALL be impossible; done in the IDLE cycle SHALL be ignored.
REQ-036 batt_low SHALL be registered and SHALL update the cycle after vld or result of BATT_SLOT changes.
REQ-037 If BATT_SLOT >= NUM_CH, batt_low SHALL be held 0.

Reset
REQ-038 When rst=1 at a clock edge, SHALL go to IDLE with wrt=0, cmd=0, result=0, vld=0, rnd_done=0, busy=0, batt_low=0, en_q=0, pointer=0.
REQ-039 Reset SHALL override every other input, including mid-transaction; the first wrt after reset SHALL appear no earlier than the second cycle after rst falls.

Verification
REQ-040 Defaults, ch_en=3'b111, single nxt, SPI model answering rd_data=slot*16'h111 after 20 cycles -> six wrt pulses with cmds 16'h0000, 16'h0000, 16'h2000, 16'h2000, 16'h2800, 16'h2800; result={12'h222,12'h111,12'h000}; vld=3'b111; one rnd_done.
REQ-041 ch_en=3'b101 -> four wrt pulses, slot1 result/vld unchanged; ch_en=0 with nxt -> busy stays 0 for 50 cycles.
REQ-042 cont=1 for two rounds, then cont=0 during round 3 -> three rnd_done pulses, and busy=0 after the third.
REQ-043 Slot-2 data 12'h7FF -> batt_low=1; next round returns 12'h800 -> batt_low=0, one cycle after vld/result update.
REQ-044 rst=1 while in WAIT_RD -> next cycle all outputs at reset values; a late done is ignored; nxt restarts at slot 0.
REQ-045 nxt pulsed during WAIT_CMD and spurious done during GAP -> no extra round, wrt count unchanged.
